pwm_peripheral: RTL
===================

Name: pwm_peripheral

Overview:
Consumes the five configuration registers written by the SPI register block and drives the 16 chip output pins. It generates one shared 8-bit PWM waveform from a prescaled free-running counter. Per bit, the block selects constant-off, constant-on or PWM. Duty-cycle updates are double-buffered and take effect only at a period boundary, so the waveform is glitch-free.

Parameters:
PRESC_DIV, 13, clock divider per PWM count; 2..65535. Period = 256*PRESC_DIV clk cycles (~3 kHz at 10 MHz).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en_reg_out_7_0  input  8  output enable for uo_out[7:0]
en_reg_out_15_8  input  8  output enable for uio_out[7:0]
en_reg_pwm_7_0  input  8  PWM select for uo_out[7:0]
en_reg_pwm_15_8  input  8  PWM select for uio_out[7:0]
pwm_duty_cycle  input  8  duty: 0x00 = 0%, 0xFF = 100%
uo_out  output  8  dedicated output pins
uio_out  output  8  bidirectional pins (output value)
period_start  output  1  one-cycle pulse on the first clk of each PWM period

Behaviour:
- Reset (async assert, sync release):
  - presc_cnt=0, pwm_cnt=0, duty_shadow=0x00.
  - uo_out=0x00, uio_out=0x00, period_start=0.
- Prescaler:
  - presc_cnt counts 0..PRESC_DIV-1 and wraps to 0.
  - tick = (presc_cnt == PRESC_DIV-1).
- PWM counter:
  - 8-bit pwm_cnt increments on tick and wraps 255 -> 0 naturally.
- Period boundary: the cycle where tick=1 and pwm_cnt=255.
  - Next cycle: pwm_cnt=0 and presc_cnt=0.
  - On that same edge, duty_shadow <= pwm_duty_cycle. Changes at any other time are ignored until the next boundary.
  - period_start is 1 exactly when pwm_cnt=0 and presc_cnt=0. It is registered with the counters, so its first pulse comes 256*PRESC_DIV cycles after reset release. It is not asserted during reset.
- PWM raw waveform (combinational from registered state):
  - pwm_raw = 1 if duty_shadow == 0xFF.
  - Otherwise pwm_raw = (pwm_cnt < duty_shadow).
  - Result: high time = duty*PRESC_DIV clocks per period; 0xFE gives 254/256; 0xFF gives constant high.
- Per-bit select, i in 0..15, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise:
  - en_out[i]=0 -> 0 (en_pwm ignored).
  - en_out[i]=1, en_pwm[i]=0 -> 1.
  - en_out[i]=1, en_pwm[i]=1 -> pwm_raw.
- Output registering:
  - The select result is registered into uo_out (bits 7:0) and uio_out (bits 15:8).
  - Enable changes are visible exactly 1 clk later.
  - Output edges lag the counter by 1 clk.
- First period after reset: duty_shadow=0, so PWM-selected bits are low for the first full period.
- Simultaneous events: a duty write on the boundary cycle is captured, last value wins. Enable changes are never deferred.
- Reset mid-period: outputs go to 0 immediately (async). Counters restart from 0.
- Inputs are treated as synchronous to clk; no extra synchronisers.

Decomposition:
- Shared package constants:
  - PWM_CNT_W = 8.
  - DUTY_FULL = 8'hFF.
  - NUM_CH = 16.
- One sub-module, pwm_timebase, holding the prescaler, pwm_cnt, tick/boundary logic and period_start.
  - Parameter: PRESC_DIV.
  - Outputs: pwm_cnt, boundary, period_start.
- Top-level pwm_peripheral holds duty_shadow, the compare and the 16-bit select/output register.

Test Plan:
- Bench parameter: PRESC_DIV = 2, giving a 512-clk period.
1. Reset with all inputs 0xFF -> uo_out=uio_out=0x00 and period_start=0 while rst_n=0. First period_start pulse comes 512 clks after release.
2. en_out=0xFFFF, en_pwm=0x0000 -> uo_out=0xFF, uio_out=0xFF exactly 1 clk after the write. Set en_reg_out_7_0=0x00 -> uo_out=0x00 1 clk later; uio_out unchanged.
3. en_out=0x0001, en_pwm=0x0001, duty=0x80, wait one boundary -> uo_out[0] high 256 clks, low 256 clks. Period measured 512 clks; rising edge 1 clk after period_start.
4. Duty 0x00 -> uo_out[0] constant 0 over 2 periods. Duty 0xFF -> constant 1 over 2 periods. Duty 0x01 -> high exactly 2 clks per period.
5. Duty 0x40, change to 0xC0 at mid-period -> current period high 128 clks, next period high 384 clks. Change on the exact boundary cycle -> the new value applies immediately.
6. en_out=0x0000, en_pwm=0xFFFF, duty=0x80 -> all outputs 0. Then en_out=0xFFFF and assert rst_n mid-period -> outputs 0 asynchronously. After release, counters restart and PWM bits stay low for one full period.

Source files
------------

// File: rtl/pwm_peripheral_pkg.sv
// Shared constants and helpers for the PWM output peripheral.
package pwm_peripheral_pkg;

    localparam int unsigned PWM_CNT_W = 8;
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
    localparam int unsigned NUM_CH = 16;

    // PWM level for a given count and duty; full-scale duty is held constantly high
    function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                       input logic [PWM_CNT_W-1:0] duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaled free-running PWM counter with period-boundary detection.
module pwm_timebase
    import pwm_peripheral_pkg::*;
#(
    parameter int unsigned PRESC_DIV = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PWM_CNT_W-1:0] pwm_cnt,
    output logic                 boundary,
    output logic                 period_start
);

    localparam int unsigned PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;

    // Prescaler terminal count and last-count-of-period detection
    always_comb begin
        tick     = (presc_cnt == PRESC_LAST);
        boundary = tick && (pwm_cnt == '1);
    end

    // Prescaler and PWM counter; pwm_cnt wraps 255 -> 0 on its own
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
            pwm_cnt   <= pwm_cnt + PWM_CNT_W'(1);
        end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

    // Registering the boundary marks the cycle where both counters sit at zero,
    // while keeping the pulse low straight out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// Drives the 16 output pins as constant-off, constant-on or shared PWM per bit.
module pwm_peripheral
    import pwm_peripheral_pkg::*;
#(
    parameter int unsigned PRESC_DIV = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] en_reg_out_7_0,
    input  logic [7:0] en_reg_out_15_8,
    input  logic [7:0] en_reg_pwm_7_0,
    input  logic [7:0] en_reg_pwm_15_8,
    input  logic [7:0] pwm_duty_cycle,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic       period_start
);

    logic [PWM_CNT_W-1:0] pwm_cnt;
    logic                 boundary;
    logic [PWM_CNT_W-1:0] duty_shadow;
    logic                 pwm_raw;
    logic [NUM_CH-1:0]    en_out;
    logic [NUM_CH-1:0]    en_pwm;
    logic [NUM_CH-1:0]    sel;

    pwm_timebase #(
        .PRESC_DIV(PRESC_DIV)
    ) u_timebase (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_cnt     (pwm_cnt),
        .boundary    (boundary),
        .period_start(period_start)
    );

    // Duty is only taken at the period boundary so a period never mixes two duties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow <= '0;
        end else if (boundary) begin
            duty_shadow <= pwm_duty_cycle;
        end
    end

    // Shared waveform and per-bit off / on / PWM selection
    always_comb begin
        en_out  = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        pwm_raw = pwm_level(pwm_cnt, duty_shadow);
        sel     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (en_out[i]) begin
                sel[i] = en_pwm[i] ? pwm_raw : 1'b1;
            end
        end
    end

    // Registered pins; outputs trail the counter by one clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uo_out  <= '0;
            uio_out <= '0;
        end else begin
            uo_out  <= sel[7:0];
            uio_out <= sel[15:8];
        end
    end

endmodule
